// File: rtl/async_fifo_drain_pkg.sv
// Shared constants for the async FIFO read-side drain engine.
package async_fifo_pkg;

  // Drain FSM encodings (plain constants so legacy tools see fixed codes)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Depth of the registered output buffer; occupancy counts 0..SKID_DEPTH in 2 bits
  localparam int SKID_DEPTH = 2;

  // Number of words held by the buffer, derived from its full/valid flags
  function automatic logic [1:0] skid_occ(input logic full, input logic valid);
    logic [1:0] occ;
    if (full) begin
      occ = 2'd2;
    end else if (valid) begin
      occ = 2'd1;
    end else begin
      occ = 2'd0;
    end
    return occ;
  endfunction

endpackage

// File: rtl/async_fifo_drain_if.sv
// FIFO read port plus registered output stream of the drain engine.
interface async_fifo_drain_if #(
  parameter int DSIZE = 32
);
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;

  // Drain engine side: pops the FIFO and sources the stream
  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data
  );

  // Environment side: FIFO model and stream sink
  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data
  );
endinterface

// File: rtl/async_fifo_drain_skid.sv
// Two-entry registered buffer: head register drives the output directly,
// tail register absorbs the word that arrives while the head is stalled.
module async_fifo_skid
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             valid,
  output logic [DSIZE-1:0] data
);

  logic [1:0]       occ_q, occ_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;

  // Next occupancy and entry contents; clear wins over push/pop
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (clear) begin
      occ_d = 2'd0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            head_d = push_data;
            occ_d  = 2'd1;
          end else begin
            occ_d = 2'd0;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = push_data;
          end else if (push) begin
            tail_d = push_data;
            occ_d  = 2'd2;
          end else if (pop) begin
            occ_d = 2'd0;
          end else begin
            occ_d = 2'd1;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d = tail_q;
            if (push) begin
              tail_d = push_data;
            end else begin
              occ_d = 2'd1;
            end
          end else begin
            occ_d = 2'd2;
          end
        end
        default: begin
          occ_d = 2'd0;
        end
      endcase
    end
  end

  // Buffer registers; contents are lost on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= {DSIZE{1'b0}};
      tail_q <= {DSIZE{1'b0}};
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign full  = (occ_q == 2'(SKID_DEPTH));
  assign valid = (occ_q != 2'd0);
  assign data  = head_q;

endmodule

// File: rtl/async_fifo_drain.sv
// Read-domain drain engine: pops a first-word-fall-through FIFO into a
// registered valid/ready stream, with enable, flush and word counters.
module async_fifo_drain
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int CW    = 16
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                en,
  input  logic                flush,
  async_fifo_drain_if.master  bus,
  output logic                busy,
  output logic [CW-1:0]       pop_cnt,
  output logic [CW-1:0]       drop_cnt
);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    pop_cnt_q, pop_cnt_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;

  logic             skid_full_s;
  logic             skid_valid_s;
  logic [DSIZE-1:0] skid_data_s;
  logic [1:0]       occ_s;
  logic             out_fire_s;
  logic             space_s;
  logic             rinc_s;
  logic             run_pop_s;
  logic             flush_pop_s;
  logic             clear_s;
  logic             push_s;
  logic [1:0]       entry_drop_s;

  assign out_fire_s = skid_valid_s & bus.m_ready;
  // A slot is free if the buffer is not full or the head leaves this cycle
  assign space_s    = ~skid_full_s | out_fire_s;
  assign occ_s      = skid_occ(skid_full_s, skid_valid_s);

  // FIFO pop strobe depends only on state, rempty and buffer space
  always_comb begin
    case (state_q)
      ST_RUN:   rinc_s = ~bus.rempty & space_s;
      ST_FLUSH: rinc_s = ~bus.rempty;
      ST_IDLE:  rinc_s = 1'b0;
      default:  rinc_s = 1'b0;
    endcase
  end

  // Next state; flush overrides everything, including en
  always_comb begin
    if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = en ? ST_RUN : ST_IDLE;
        ST_RUN:   state_d = en ? ST_RUN : ST_IDLE;
        ST_FLUSH: state_d = bus.rempty ? ST_IDLE : ST_FLUSH;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign run_pop_s   = (state_q == ST_RUN) & rinc_s;
  assign flush_pop_s = (state_q == ST_FLUSH) & rinc_s;
  // Buffer is emptied on the edge that enters FLUSH
  assign clear_s     = (state_d == ST_FLUSH) & (state_q != ST_FLUSH);
  assign push_s      = run_pop_s & ~clear_s;

  // Words discarded at flush entry: what the buffer would have held after
  // this edge (a word accepted downstream on that edge was delivered, and a
  // word popped from the FIFO on that edge is lost with the buffer)
  always_comb begin
    if (clear_s) begin
      entry_drop_s = occ_s - {1'b0, out_fire_s} + {1'b0, run_pop_s};
    end else begin
      entry_drop_s = 2'd0;
    end
  end

  // Counter updates; pop and drop increments land together on the entry edge
  always_comb begin
    pop_cnt_d  = pop_cnt_q + CW'(run_pop_s);
    drop_cnt_d = drop_cnt_q + CW'(entry_drop_s) + CW'(flush_pop_s);
  end

  // FSM and counter registers
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q    <= ST_IDLE;
      pop_cnt_q  <= {CW{1'b0}};
      drop_cnt_q <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      pop_cnt_q  <= pop_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  async_fifo_skid #(
    .DSIZE (DSIZE)
  ) u_skid (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (push_s),
    .push_data (bus.rdata),
    .pop       (out_fire_s),
    .clear     (clear_s),
    .full      (skid_full_s),
    .valid     (skid_valid_s),
    .data      (skid_data_s)
  );

  assign bus.rinc    = rinc_s;
  assign bus.m_valid = skid_valid_s;
  assign bus.m_data  = skid_data_s;
  assign busy        = (state_q != ST_IDLE) | skid_valid_s;
  assign pop_cnt     = pop_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
